// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard and write-collision flag; reg 0 reads as zero.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int N_BITS = 32,
    parameter int N_REGS = 32,
    parameter int N_RD   = 2,
    parameter int N_WR   = 1,
    localparam int N_IDX = $clog2(N_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD*N_IDX-1:0]    rd_idx,
    output logic [N_RD*N_BITS-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*N_IDX-1:0]    wr_idx,
    input  logic [N_WR*N_BITS-1:0]   wr_data,
    input  logic                     claim_en,
    input  logic [N_IDX-1:0]         claim_idx,
    output logic [N_REGS-1:0]        busy_vec,
    output logic                     wr_conflict
);

    logic [N_BITS-1:0] regs_q [N_REGS];
    logic [N_BITS-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] busy_d;
    logic              conflict_q;
    logic              conflict_d;

    // Next-state: writes (highest port wins), scoreboard clear-then-set, collision detect
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        conflict_d = 1'b0;
        // Index 0 is skipped so it stays zero and never turns busy
        for (int i = 1; i < N_REGS; i++) begin
            for (int w = 0; w < N_WR; w++) begin
                regs_d[i] = (wr_en[w] && (wr_idx[w*N_IDX +: N_IDX] == N_IDX'(i)))
                            ? wr_data[w*N_BITS +: N_BITS] : regs_d[i];
                busy_d[i] = busy_d[i] &
                            ~(wr_en[w] && (wr_idx[w*N_IDX +: N_IDX] == N_IDX'(i)));
            end
            busy_d[i] = busy_d[i] | (claim_en && (claim_idx == N_IDX'(i)));
        end
        for (int a = 0; a < N_WR; a++) begin
            for (int b = a + 1; b < N_WR; b++) begin
                conflict_d = conflict_d |
                    (wr_en[a] && wr_en[b] &&
                     (wr_idx[a*N_IDX +: N_IDX] == wr_idx[b*N_IDX +: N_IDX]) &&
                     (wr_idx[a*N_IDX +: N_IDX] != {N_IDX{1'b0}}));
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            busy_q     <= {N_REGS{1'b0}};
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data
    always_comb begin
        rd_data = {(N_RD*N_BITS){1'b0}};
        rd_busy = {N_RD{1'b0}};
        for (int p = 0; p < N_RD; p++) begin
            rd_data[p*N_BITS +: N_BITS] = regs_q[rd_idx[p*N_IDX +: N_IDX]];
            rd_busy[p]                  = busy_q[rd_idx[p*N_IDX +: N_IDX]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < N_WR; w++) begin
                rd_data[p*N_BITS +: N_BITS] =
                    (wr_en[w] && (wr_idx[w*N_IDX +: N_IDX] == rd_idx[p*N_IDX +: N_IDX]) &&
                     (rd_idx[p*N_IDX +: N_IDX] != {N_IDX{1'b0}}))
                    ? wr_data[w*N_BITS +: N_BITS] : rd_data[p*N_BITS +: N_BITS];
                rd_busy[p] = rd_busy[p] &
                    ~(wr_en[w] && (wr_idx[w*N_IDX +: N_IDX] == rd_idx[p*N_IDX +: N_IDX]) &&
                      (rd_idx[p*N_IDX +: N_IDX] != {N_IDX{1'b0}}));
            end
`endif
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

endmodule
